// File: rtl/poly_pkg.sv
// Shared types and sizing for the Horner polynomial evaluator.
package poly_pkg;

  localparam int unsigned MAX_DEGREE = 15;
  localparam int unsigned CNT_W      = $clog2(MAX_DEGREE + 1);

  typedef enum logic [1:0] {
    LOAD_COEF,
    LOAD_X,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/poly_horner_if.sv
// Word stream in, held result out; master drives words, slave is the evaluator.
interface poly_horner_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             reuse;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             overflow;
  logic             busy;

  modport master (
    output data_in, in_valid, reuse,
    input  in_ready, result, result_valid, overflow, busy
  );

  modport slave (
    input  data_in, in_valid, reuse,
    output in_ready, result, result_valid, overflow, busy
  );

endinterface

// File: rtl/poly_mac.sv
// One Horner step: acc*x + coef, truncated to WIDTH with an overflow flag.
module poly_mac #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] coef_i,
  output logic [WIDTH-1:0] next_acc_o,
  output logic             ovf_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = PW + 1;

  logic [PW-1:0] prod;
  logic [SW-1:0] sum;

  always_comb begin
    prod       = PW'(acc_i) * PW'(x_i);
    sum        = SW'(prod) + SW'(coef_i);
    next_acc_o = sum[WIDTH-1:0];
    ovf_o      = |sum[SW-1:WIDTH];
  end

endmodule

// File: rtl/poly_horner.sv
// Polynomial evaluator: loads a_N..a_0 then x, one multiply-add per cycle.
module poly_horner
  import poly_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEGREE = 2
) (
  input  logic         clk,
  input  logic         reset,
  poly_horner_if.slave bus
);

  localparam logic [CNT_W-1:0] TOP = CNT_W'(DEGREE);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] step_q;
  logic [WIDTH-1:0] coef_q [0:DEGREE];
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             ovf_q;

  logic             xfer;
  logic [WIDTH-1:0] coef_sel;
  logic [WIDTH-1:0] acc_d;
  logic             mac_ovf;

  assign bus.in_ready     = (state_q != CALC);
  assign bus.busy         = (state_q == CALC);
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.overflow     = ovf_q;
  assign xfer             = bus.in_valid && bus.in_ready;

  // Coefficient for the current Horner step.
  always_comb begin
    coef_sel = '0;
    for (int i = 0; i <= int'(DEGREE); i++) begin
      if (step_q == CNT_W'(i)) coef_sel = coef_q[i];
    end
  end

  poly_mac #(.WIDTH(WIDTH)) u_mac (
    .acc_i      (acc_q),
    .x_i        (x_q),
    .coef_i     (coef_sel),
    .next_acc_o (acc_d),
    .ovf_o      (mac_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD_COEF;
      count_q  <= '0;
      step_q   <= '0;
      for (int i = 0; i <= int'(DEGREE); i++) coef_q[i] <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        LOAD_COEF: begin
          if (xfer) begin
            for (int i = 0; i <= int'(DEGREE); i++) begin
              if ((TOP - count_q) == CNT_W'(i)) coef_q[i] <= bus.data_in;
            end
            if (count_q == TOP) begin
              count_q <= '0;
              state_q <= LOAD_X;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        LOAD_X: begin
          if (xfer) begin
            x_q     <= bus.data_in;
            acc_q   <= coef_q[DEGREE];
            step_q  <= TOP - CNT_W'(1);
            ovf_q   <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          ovf_q <= ovf_q | mac_ovf;
          if (step_q == '0) begin
            result_q <= acc_d;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            step_q <= step_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (xfer) begin
            valid_q <= 1'b0;
            if (bus.reuse) begin
              // New x against the coefficients already held.
              x_q     <= bus.data_in;
              acc_q   <= coef_q[DEGREE];
              step_q  <= TOP - CNT_W'(1);
              ovf_q   <= 1'b0;
              state_q <= CALC;
            end else begin
              coef_q[DEGREE] <= bus.data_in;
              count_q        <= CNT_W'(1);
              state_q        <= LOAD_COEF;
            end
          end
        end
        default: state_q <= LOAD_COEF;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_horner.sv
// Scoreboard bench for poly_horner at degree 2 and degree 3, WIDTH 8.
module tb_poly_horner;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] sb [$];
  logic [7:0] c2 [0:15];
  logic [7:0] c3 [0:15];

  poly_horner_if #(.WIDTH(8)) if2 ();
  poly_horner_if #(.WIDTH(8)) if3 ();

  poly_horner #(.WIDTH(8), .DEGREE(2)) dut2 (.clk(clk), .reset(rst), .bus(if2));
  poly_horner #(.WIDTH(8), .DEGREE(3)) dut3 (.clk(clk), .reset(rst), .bus(if3));

  always #5 clk = ~clk;

  // Reference Horner evaluation; c[0] is a_N (first word sent). Returns {ovf, result}.
  function automatic logic [8:0] model(input int n, input logic [7:0] c [0:15], input logic [7:0] x);
    int   acc;
    int   s;
    logic ov;
    acc = int'(c[0]);
    ov  = 1'b0;
    for (int i = 1; i <= n; i++) begin
      s = acc * int'(x) + int'(c[i]);
      if (s > 255) ov = 1'b1;
      acc = s % 256;
    end
    return {ov, 8'(acc)};
  endfunction

  task automatic send2(input logic [7:0] w, input logic r);
    int n = 0;
    @(negedge clk);
    if2.data_in = w; if2.in_valid = 1'b1; if2.reuse = r;
    while (!if2.in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send2_timeout: in_ready never rose for word %0h", w);
    end
    @(posedge clk);
    #1 if2.in_valid = 1'b0; if2.reuse = 1'b0;
  endtask

  task automatic send3(input logic [7:0] w);
    int n = 0;
    @(negedge clk);
    if3.data_in = w; if3.in_valid = 1'b1; if3.reuse = 1'b0;
    while (!if3.in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send3_timeout: in_ready never rose for word %0h", w);
    end
    @(posedge clk);
    #1 if3.in_valid = 1'b0;
  endtask

  task automatic load2(input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0);
    c2[0] = a2; c2[1] = a1; c2[2] = a0;
    send2(a2, 1'b0); send2(a1, 1'b0); send2(a0, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (if2.result !== 8'h00) begin errors++; $display("FAIL rst_result: got %0h want 0", if2.result); end
    checks++; if (if2.result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if2.result_valid); end
    checks++; if (if2.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", if2.overflow); end
    checks++; if (if2.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", if2.busy); end
    checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", if2.in_ready); end
    checks++; if (if3.in_ready !== 1'b1 || if3.result_valid !== 1'b0) begin
      errors++; $display("FAIL rst_dut3: ready %b valid %b want 1 0", if3.in_ready, if3.result_valid);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_load();
    logic [8:0] exp;
    int lat = 0;
    load2(8'd2, 8'd3, 8'd4);
    send2(8'd5, 1'b0);
    sb.push_back(model(2, c2, 8'd5));
    do begin @(negedge clk); lat++; end while (!if2.result_valid && lat < 40);
    exp = sb.pop_front();
    checks++; if (lat != 3) begin errors++; $display("FAIL load_latency: got %0d want 3", lat); end
    checks++; if (if2.result !== exp[7:0]) begin errors++; $display("FAIL load_result: got %0h want %0h", if2.result, exp[7:0]); end
    checks++; if (if2.overflow !== exp[8]) begin errors++; $display("FAIL load_ovf: got %b want %b", if2.overflow, exp[8]); end
    repeat (3) @(negedge clk);
    checks++; if (if2.result_valid !== 1'b1 || if2.result !== exp[7:0]) begin
      errors++; $display("FAIL load_hold: valid %b result %0h want 1 %0h", if2.result_valid, if2.result, exp[7:0]);
    end
  endtask

  task automatic test_reuse();
    logic [8:0] exp;
    int lat = 0;
    send2(8'd2, 1'b1);
    sb.push_back(model(2, c2, 8'd2));
    do begin @(negedge clk); lat++; end while (!if2.result_valid && lat < 40);
    exp = sb.pop_front();
    checks++; if (lat != 3) begin errors++; $display("FAIL reuse_latency: got %0d want 3", lat); end
    checks++; if (if2.result !== exp[7:0]) begin errors++; $display("FAIL reuse_result: got %0h want %0h", if2.result, exp[7:0]); end
    checks++; if (if2.overflow !== exp[8]) begin errors++; $display("FAIL reuse_ovf: got %b want %b", if2.overflow, exp[8]); end
  endtask

  task automatic test_overflow();
    logic [8:0] exp;
    int lat = 0;
    load2(8'd16, 8'd0, 8'd0);
    send2(8'd5, 1'b0);
    sb.push_back(model(2, c2, 8'd5));
    do begin @(negedge clk); lat++; end while (!if2.result_valid && lat < 40);
    exp = sb.pop_front();
    checks++; if (if2.result !== exp[7:0]) begin errors++; $display("FAIL ovf_result: got %0h want %0h", if2.result, exp[7:0]); end
    checks++; if (if2.overflow !== exp[8]) begin errors++; $display("FAIL ovf_flag: got %b want %b", if2.overflow, exp[8]); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int lat = 0;
    load2(8'd2, 8'd3, 8'd4);
    @(negedge clk);
    if2.data_in = 8'd5; if2.in_valid = 1'b1; if2.reuse = 1'b0;
    @(posedge clk);
    #1 if2.reuse = 1'b1;
    sb.push_back(model(2, c2, 8'd5));
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      checks++; if (if2.in_ready !== 1'b0 || if2.busy !== 1'b1) begin
        errors++; $display("FAIL bp_calc%0d: ready %b busy %b want 0 1", cyc, if2.in_ready, if2.busy);
      end
      if2.data_in = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (if2.in_ready !== 1'b1 || if2.result_valid !== 1'b1) begin
      errors++; $display("FAIL bp_done: ready %b valid %b want 1 1", if2.in_ready, if2.result_valid);
    end
    checks++; if (if2.result !== exp[7:0] || if2.overflow !== exp[8]) begin
      errors++; $display("FAIL bp_result: got %b_%0h want %b_%0h", if2.overflow, if2.result, exp[8], exp[7:0]);
    end
    if2.data_in = 8'd1;
    @(posedge clk);
    #1 if2.in_valid = 1'b0; if2.reuse = 1'b0;
    sb.push_back(model(2, c2, 8'd1));
    do begin @(negedge clk); lat++; end while (!if2.result_valid && lat < 40);
    exp = sb.pop_front();
    checks++; if (lat != 3 || if2.result !== exp[7:0]) begin
      errors++; $display("FAIL bp_next: lat %0d result %0h want 3 %0h", lat, if2.result, exp[7:0]);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [8:0] exp;
    int lat = 0;
    load2(8'd1, 8'd1, 8'd1);
    send2(8'd2, 1'b0);
    @(negedge clk);
    checks++; if (if2.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", if2.busy); end
    rst = 1'b1;
    #1;
    checks++; if (if2.result !== 8'h00 || if2.result_valid !== 1'b0 || if2.overflow !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out: result %0h valid %b ovf %b want 0 0 0", if2.result, if2.result_valid, if2.overflow);
    end
    checks++; if (if2.busy !== 1'b0 || if2.in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_hs: busy %b ready %b want 0 1", if2.busy, if2.in_ready);
    end
    @(negedge clk); rst = 1'b0;
    load2(8'd1, 8'd1, 8'd1);
    send2(8'd2, 1'b0);
    sb.push_back(model(2, c2, 8'd2));
    do begin @(negedge clk); lat++; end while (!if2.result_valid && lat < 40);
    exp = sb.pop_front();
    checks++; if (lat != 3 || if2.result !== exp[7:0]) begin
      errors++; $display("FAIL mid_reload: lat %0d result %0h want 3 %0h", lat, if2.result, exp[7:0]);
    end
  endtask

  task automatic test_degree3();
    logic [8:0] exp;
    int lat = 0;
    c3[0] = 8'd1; c3[1] = 8'd0; c3[2] = 8'd0; c3[3] = 8'd1;
    for (int i = 0; i < 4; i++) send3(c3[i]);
    send3(8'd3);
    sb.push_back(model(3, c3, 8'd3));
    do begin @(negedge clk); lat++; end while (!if3.result_valid && lat < 40);
    exp = sb.pop_front();
    checks++; if (lat != 4) begin errors++; $display("FAIL deg3_latency: got %0d want 4", lat); end
    checks++; if (if3.result !== exp[7:0] || if3.overflow !== exp[8]) begin
      errors++; $display("FAIL deg3_result: got %b_%0h want %b_%0h", if3.overflow, if3.result, exp[8], exp[7:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    if2.data_in = '0; if2.in_valid = 1'b0; if2.reuse = 1'b0;
    if3.data_in = '0; if3.in_valid = 1'b0; if3.reuse = 1'b0;
    for (int i = 0; i < 16; i++) begin c2[i] = '0; c3[i] = '0; end
    test_reset();
    test_load();
    test_reuse();
    test_overflow();
    test_back_to_back();
    test_reset_mid_calc();
    test_degree3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
